// File: rtl/preprocess_seq.sv
// preprocess_seq: sequencer for the coefficient preprocess datapath ahead of the
// NTT/INTT core. On start it streams N coefficients out of a dual-port RAM,
// routes each one through the external combinational preprocess block
// (pp_x -> pp_z), and writes the result back to the same address two cycles
// after it was read.
//
// Optional build macro:
//   PREPROCESS_SEQ_RANGE_CHECK_EN - builds a sticky err flag that is set when a
//   coefficient read back from RAM is >= Q. Without it, err is tied low and no
//   compare logic exists.
module preprocess_seq #(
    parameter int N  = 256,
    parameter int AW = 8,
    parameter int DW = 12,
    parameter int Q  = 3329
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [DW-1:0] pp_x,
    output logic          NTT_INTT_sel,
    input  logic [DW-1:0] pp_z
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One bit wider than the address so the terminal count N is reachable
    // without wrapping back to zero.
    localparam logic [AW:0] LAST_CNT = (AW+1)'(N);

    logic [1:0]    state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          mode_q, mode_d;
    logic          issue;

    logic          valid1_q, valid1_d;
    logic [AW-1:0] addr1_q, addr1_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    // Control: run-state transitions, read issue and the issue counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    count_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    issue   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_d == LAST_CNT) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // The write sitting on the bus this cycle lands at this edge,
                // so only an unconsumed read result keeps us here.
                if (!valid1_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-stage pipe: read result captured into stage 1, written back from stage 2.
    always_comb begin
        valid1_d  = issue;
        addr1_d   = rd_addr;
        wr_en_d   = valid1_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (valid1_q) begin
            wr_addr_d = addr1_q;
            wr_data_d = pp_z;
        end
    end

    // State and pipeline registers; reset also discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            mode_q    <= 1'b0;
            valid1_q  <= 1'b0;
            addr1_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            valid1_q  <= valid1_d;
            addr1_q   <= addr1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef PREPROCESS_SEQ_RANGE_CHECK_EN
    localparam logic [DW:0] Q_EXT = (DW+1)'(Q);

    logic err_q, err_d;

    // Sticky out-of-range flag: cleared by an accepted start, set by any bad read.
    always_comb begin
        err_d = err_q;
        if (state_q == S_IDLE && start) begin
            err_d = 1'b0;
        end else if (valid1_q && ({1'b0, rd_data} >= Q_EXT)) begin
            err_d = 1'b1;
        end
    end

    // Range flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done         = (state_q == S_DONE);
    assign rd_en        = issue;
    assign rd_addr      = (state_q == S_RUN) ? count_q[AW-1:0] : '0;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign pp_x         = rd_data;
    assign NTT_INTT_sel = mode_q;

endmodule

// File: tb/tb_preprocess_seq.sv
// Testbench for preprocess_seq. Provides a synchronous dual-port RAM and a
// behavioural preprocess block, then checks timing, write-back contents,
// stalls, ignored starts, mid-run reset and (when PREPROCESS_SEQ_RANGE_CHECK_EN
// is defined) the sticky range flag.
module tb_preprocess_seq;

    localparam int N    = 256;
    localparam int AW   = 8;
    localparam int DW   = 12;
    localparam int Q    = 3329;
    localparam int MAXC = 4 * N + 64;

    logic          clk = 1'b0;
    logic          rst, start, mode, stall;
    logic          busy, done, err, rd_en, wr_en, NTT_INTT_sel;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] wr_data, pp_x, pp_z;

    logic [DW-1:0] mem        [0:N-1];
    logic [DW-1:0] init_image [0:N-1];
    logic          load_all = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    int   last_done_cycle;
    int   done_pulses;
    logic err_at_done;
    logic err_at_c1;

    preprocess_seq #(.N(N), .AW(AW), .DW(DW), .Q(Q)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .stall        (stall),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pp_x         (pp_x),
        .NTT_INTT_sel (NTT_INTT_sel),
        .pp_z         (pp_z)
    );

    always #5 clk = ~clk;

    // Preprocess behaviour: NTT passes through, INTT scales by 3303 (= -26) mod Q.
    function automatic logic [DW-1:0] ppModel(input logic sel, input logic [DW-1:0] x);
        int v;
        v = int'(x);
        if (!sel) v = (v * 3303) % Q;
        return v[DW-1:0];
    endfunction

    assign pp_z = ppModel(NTT_INTT_sel, pp_x);

    // Synchronous dual-port RAM with a bulk-load path for test setup.
    always @(posedge clk) begin
        if (load_all) begin
            for (int i = 0; i < N; i++) mem[i] <= init_image[i];
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // kind 0: full 12-bit random, 1: identity, 2: random below Q
    task automatic fillImage(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                1:       init_image[i] = DW'(i);
                2:       init_image[i] = DW'($urandom_range(0, Q - 1));
                default: init_image[i] = DW'($urandom_range(0, (1 << DW) - 1));
            endcase
        end
    endtask

    task automatic commitImage();
        @(posedge clk); #1 load_all = 1'b1;
        @(posedge clk); #1 load_all = 1'b0;
    endtask

    // One run: start accepted at edge 0, then every cycle is compared with a
    // schedule derived from the stall pattern and the RAM snapshot.
    task automatic applyStimulus(input string tag, input logic run_mode,
                                 input int stall_lo, input int stall_hi, input int stall_pct,
                                 input int mid_start, input int rst_cycle);
        logic [DW-1:0] snap [N];
        bit   stall_vec   [MAXC];
        int   rd_addr_at  [MAXC];
        int   rd_cycle    [N];
        int   issued, last_rd, bad_from, total, a;
        int   cyc_errs, hazards, wr_count, busy_count, exp_writes, ram_errs;
        logic live, e_rd, e_wr, e_busy, e_done, e_err, bad;
        logic [DW-1:0] exp_val;

        for (int i = 0; i < N; i++) snap[i] = mem[i];
        for (int c = 0; c < MAXC; c++) begin
            stall_vec[c]  = ((c >= stall_lo) && (c <= stall_hi)) ||
                            (int'($urandom_range(0, 99)) < stall_pct);
            rd_addr_at[c] = -1;
        end

        issued  = 0;
        last_rd = 0;
        for (int c = 1; c < MAXC - 8 && issued < N; c++) begin
            if (!stall_vec[c]) begin
                rd_addr_at[c]    = issued;
                rd_cycle[issued] = c;
                issued++;
                last_rd = c;
            end
        end

        bad_from = 2 * MAXC;
`ifdef PREPROCESS_SEQ_RANGE_CHECK_EN
        for (int i = 0; i < N; i++)
            if (int'(snap[i]) >= Q && rd_cycle[i] + 2 < bad_from) bad_from = rd_cycle[i] + 2;
`endif

        total = (rst_cycle > 0) ? rst_cycle + 15 : last_rd + 7;
        cyc_errs = 0; hazards = 0; wr_count = 0; busy_count = 0;
        done_pulses = 0; last_done_cycle = -1;
        err_at_done = 1'bx; err_at_c1 = 1'bx;

        @(posedge clk); #1;
        start = 1'b1; mode = run_mode; stall = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int c = 1; c <= total; c++) begin
            stall = stall_vec[c];
            start = (c == mid_start);
            mode  = (c == mid_start) ? ~run_mode : run_mode;
            rst   = (rst_cycle != 0) && (c == rst_cycle);
            @(negedge clk);
            live   = (rst_cycle == 0) || (c <= rst_cycle);
            e_rd   = live && (rd_addr_at[c] >= 0);
            e_wr   = live && (c >= 3) && (rd_addr_at[(c >= 3) ? c - 2 : 0] >= 0);
            e_busy = live && (c <= last_rd + 2);
            e_done = live && (c == last_rd + 3);
            e_err  = live && (c >= bad_from);
            bad    = 1'b0;
            if (rd_en !== e_rd) bad = 1'b1;
            else if (e_rd && rd_addr !== AW'(rd_addr_at[c])) bad = 1'b1;
            if (wr_en !== e_wr) bad = 1'b1;
            else if (e_wr) begin
                a = rd_addr_at[c - 2];
                if (wr_addr !== AW'(a) || wr_data !== ppModel(run_mode, snap[a])) bad = 1'b1;
            end
            if (busy !== e_busy || done !== e_done || err !== e_err) bad = 1'b1;
            if (e_busy && NTT_INTT_sel !== run_mode) bad = 1'b1;
            if (!live && (NTT_INTT_sel !== 1'b0 || rd_addr !== '0 ||
                          wr_addr !== '0 || wr_data !== '0)) bad = 1'b1;
            if (rd_en === 1'b1 && wr_en === 1'b1 && rd_addr === wr_addr) hazards++;
            if (bad) begin
                cyc_errs++;
                if (cyc_errs == 1)
                    $display("[TB] %s first divergence at cycle %0d: rd_en=%b rd_addr=%0d wr_en=%b wr_addr=%0d wr_data=%0d busy=%b done=%b err=%b sel=%b",
                             tag, c, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err, NTT_INTT_sel);
            end
            if (done === 1'b1) begin
                done_pulses++;
                if (last_done_cycle < 0) last_done_cycle = c;
            end
            if (wr_en === 1'b1) wr_count++;
            if (busy === 1'b1) busy_count++;
            if (c == 1) err_at_c1 = err;
            if (c == last_rd + 3) err_at_done = err;
            @(posedge clk); #1;
        end
        stall = 1'b0; start = 1'b0; rst = 1'b0;

        exp_writes = 0;
        ram_errs   = 0;
        for (int i = 0; i < N; i++) begin
            if (rst_cycle == 0 || rd_cycle[i] + 2 <= rst_cycle) begin
                exp_writes++;
                exp_val = ppModel(run_mode, snap[i]);
            end else begin
                exp_val = snap[i];
            end
            if (mem[i] !== exp_val) ram_errs++;
        end

        checkOutput({tag, "_cycle_errs"}, cyc_errs, 0);
        checkOutput({tag, "_hazards"}, hazards, 0);
        checkOutput({tag, "_wr_count"}, wr_count, exp_writes);
        checkOutput({tag, "_ram_errs"}, ram_errs, 0);
        if (rst_cycle == 0) begin
            checkOutput({tag, "_done_cycle"}, last_done_cycle, last_rd + 3);
            checkOutput({tag, "_done_pulses"}, done_pulses, 1);
            checkOutput({tag, "_busy_cycles"}, busy_count, last_rd + 2);
        end else begin
            checkOutput({tag, "_done_pulses"}, done_pulses, 0);
        end
    endtask

    typedef struct {
        string name;
        logic  run_mode;
        int    stall_lo;
        int    stall_hi;
        int    init_kind;
        int    exp_done;
    } run_vec_t;

    typedef struct {
        int addr;
        int init_val;
        int exp_val;
    } coef_vec_t;

    run_vec_t  run_tbl [3];
    coef_vec_t t1_tbl  [4];

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int id_errs;

        run_tbl[0] = '{name: "t1_intt",  run_mode: 1'b0, stall_lo: 0, stall_hi: -1, init_kind: 0, exp_done: N + 3};
        run_tbl[1] = '{name: "t2_ntt",   run_mode: 1'b1, stall_lo: 0, stall_hi: -1, init_kind: 1, exp_done: N + 3};
        run_tbl[2] = '{name: "t3_stall", run_mode: 1'b0, stall_lo: 5, stall_hi: 9,  init_kind: 1, exp_done: N + 8};

        t1_tbl[0] = '{addr: 0, init_val: 0,    exp_val: 0};
        t1_tbl[1] = '{addr: 1, init_val: 1,    exp_val: 3303};
        t1_tbl[2] = '{addr: 2, init_val: 1664, exp_val: 13};
        t1_tbl[3] = '{addr: 3, init_val: 1665, exp_val: 3316};

        rst = 1'b1; start = 1'b0; mode = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flags", int'({busy, done, err, rd_en, wr_en, NTT_INTT_sel}), 0);
        checkOutput("reset_rd_addr", int'(rd_addr), 0);
        checkOutput("reset_wr_addr", int'(wr_addr), 0);
        checkOutput("reset_wr_data", int'(wr_data), 0);
        @(posedge clk); #1 rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            fillImage(run_tbl[t].init_kind);
            if (t == 0)
                for (int k = 0; k < 4; k++) init_image[t1_tbl[k].addr] = DW'(t1_tbl[k].init_val);
            commitImage();
            applyStimulus(run_tbl[t].name, run_tbl[t].run_mode, run_tbl[t].stall_lo,
                          run_tbl[t].stall_hi, 0, 0, 0);
            checkOutput({run_tbl[t].name, "_done_at"}, last_done_cycle, run_tbl[t].exp_done);
            if (t == 0)
                for (int k = 0; k < 4; k++)
                    checkOutput($sformatf("t1_coef%0d", t1_tbl[k].addr),
                                int'(mem[t1_tbl[k].addr]), t1_tbl[k].exp_val);
            if (t == 1) begin
                id_errs = 0;
                for (int i = 0; i < N; i++) if (mem[i] !== DW'(i)) id_errs++;
                checkOutput("t2_ram_unchanged", id_errs, 0);
            end
        end

        // Start pulsed with the opposite mode in the middle of a run.
        fillImage(2);
        commitImage();
        applyStimulus("t4_midstart", 1'b1, 0, -1, 0, 30, 0);
        checkOutput("t4_done_at", last_done_cycle, N + 3);

        // Synchronous reset during a run, then a clean run afterwards.
        fillImage(2);
        commitImage();
        applyStimulus("t5_reset", 1'b0, 0, -1, 0, 0, 20);
        applyStimulus("t5_rerun", 1'b0, 0, -1, 0, 0, 0);
        checkOutput("t5_rerun_done_at", last_done_cycle, N + 3);

`ifdef PREPROCESS_SEQ_RANGE_CHECK_EN
        fillImage(2);
        init_image[7] = DW'(Q);
        commitImage();
        applyStimulus("t6_range", 1'b1, 0, -1, 0, 0, 0);
        checkOutput("t6_err_at_done", int'(err_at_done), 1);
        checkOutput("t6_err_held_idle", int'(err), 1);
        applyStimulus("t6_restart", 1'b1, 0, -1, 0, 0, 0);
        checkOutput("t6_err_cleared_c1", int'(err_at_c1), 0);
        checkOutput("t6_err_again_done", int'(err_at_done), 1);
`endif

        // Randomized runs: random contents, mode, stall density and stray starts.
        for (int r = 0; r < 6; r++) begin
            fillImage(0);
            commitImage();
            applyStimulus($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0, -1,
                          int'($urandom_range(0, 40)),
                          (r % 2 == 1) ? int'($urandom_range(2, N)) : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
